// File: rtl/depacketizer_da_stream.sv
// Flit-serial dest-append depacketizer: reassembles NoC packets, extracts the
// return destination/VC from the head payload and queues packets in a show-ahead FIFO.
module depacketizer_da_stream #(
  parameter int WIDTH_FLIT       = 36,
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int NUM_FLITS        = 2,
  parameter int WIDTH_DATA       = 48,
  parameter int DEPTH            = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH_FLIT-1:0]       data_in,
  input  logic                        valid_in,
  output logic                        ready_out,
  output logic [WIDTH_DATA-1:0]       data_out,
  output logic [ADDRESS_WIDTH-1:0]    dst_out,
  output logic [VC_ADDRESS_WIDTH-1:0] vc_out,
  output logic                        valid_out,
  input  logic                        ready_in,
  output logic                        err_out
);

  localparam int PW      = WIDTH_FLIT - 3 - ADDRESS_WIDTH - VC_ADDRESS_WIDTH;
  localparam int ASM_W   = NUM_FLITS * PW;
  localparam int ENTRY_W = ADDRESS_WIDTH + VC_ADDRESS_WIDTH + WIDTH_DATA;
  localparam int IDX_W   = $clog2(NUM_FLITS + 1);
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  typedef enum logic {S_IDLE, S_ASSEMBLE} state_t;

  state_t              r_state, w_state_next;
  logic [IDX_W-1:0]    r_idx, w_idx_next;
  logic [ASM_W-1:0]    r_asm, w_asm_next;
  logic                r_err, w_err_next;
  logic                w_push, w_pop, w_accept;

  logic                w_flit_v, w_h, w_t;
  logic [PW-1:0]       w_payload;
  logic                w_unused;

  assign w_flit_v  = data_in[WIDTH_FLIT-1];
  assign w_h       = data_in[WIDTH_FLIT-2];
  assign w_t       = data_in[WIDTH_FLIT-3];
  assign w_payload = data_in[PW-1:0];
  // Routing dest/VC fields only matter to the network, not to reassembly.
  assign w_unused  = &{1'b0, data_in[WIDTH_FLIT-4 -: ADDRESS_WIDTH + VC_ADDRESS_WIDTH]};

  assign w_accept  = valid_in & ready_out & w_flit_v;

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_asm_next   = r_asm;
    w_err_next   = 1'b0;
    w_push       = 1'b0;
    if (w_accept) begin
      if (r_state == S_IDLE || w_h) begin
        // A head arriving mid-packet abandons the partial packet and restarts.
        if (r_state == S_ASSEMBLE) w_err_next = 1'b1;
        if (w_h) begin
          w_asm_next = '0;
          w_asm_next[ASM_W-1 -: PW] = w_payload;
          if (w_t) begin
            w_push       = 1'b1;
            w_state_next = S_IDLE;
            w_idx_next   = '0;
          end else begin
            w_state_next = S_ASSEMBLE;
            w_idx_next   = IDX_W'(1);
          end
        end else begin
          w_err_next = 1'b1;
        end
      end else begin
        if (r_idx < IDX_W'(NUM_FLITS)) begin
          for (int k = 1; k < NUM_FLITS; k++) begin
            if (r_idx == IDX_W'(k)) w_asm_next[ASM_W-1-k*PW -: PW] = w_payload;
          end
          w_idx_next = r_idx + IDX_W'(1);
        end else begin
          w_err_next = 1'b1;
        end
        if (w_t) begin
          w_push       = 1'b1;
          w_state_next = S_IDLE;
          w_idx_next   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_asm   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_asm   <= w_asm_next;
      r_err   <= w_err_next;
    end
  end

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [ENTRY_W-1:0] w_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_pop = valid_out & ready_in;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_asm_next[ASM_W-1 -: ENTRY_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign valid_out = (r_count != '0);
  assign ready_out = (r_count != CNT_W'(DEPTH));
  // Mask the head so outputs read zero whenever the FIFO is empty.
  assign w_head    = valid_out ? r_mem[r_rd_ptr] : '0;
  assign dst_out   = w_head[ENTRY_W-1 -: ADDRESS_WIDTH];
  assign vc_out    = w_head[ENTRY_W-1-ADDRESS_WIDTH -: VC_ADDRESS_WIDTH];
  assign data_out  = w_head[WIDTH_DATA-1:0];
  assign err_out   = r_err;

endmodule
